// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline control path: opcode map,
// ALU-op classes, the EX control bundle and the hazard FSM states.
package pipe_pkg;

    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned LAST_RTYPE = 4;
    localparam int unsigned LAST_ITYPE = 9;
    localparam int unsigned OP_LW      = 10;
    localparam int unsigned OP_SW      = 11;
    localparam int unsigned OP_BR      = 12;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode -> control bundle table, shared with the
// single-cycle core. Also flags undefined opcodes and rt-reading opcodes.
module ctrl_decode
    import pipe_pkg::*;
#(
    parameter int unsigned OP_W    = OPCODE_W,
    parameter int unsigned R_LAST  = LAST_RTYPE,
    parameter int unsigned I_LAST  = LAST_ITYPE,
    parameter int unsigned LW_CODE = OP_LW,
    parameter int unsigned SW_CODE = OP_SW,
    parameter int unsigned BR_CODE = OP_BR
) (
    input  logic [OP_W-1:0] opcode,
    output ctrl_t           ctrl,
    output logic            illegal,
    output logic            uses_rt
);

    logic [31:0] op32;

    assign op32 = {{(32-OP_W){1'b0}}, opcode};

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        uses_rt = 1'b0;
        if (op32 <= R_LAST) begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
            uses_rt        = 1'b1;
        end else if (op32 <= I_LAST) begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
        end else if (op32 == LW_CODE) begin
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.alu_op     = ALUOP_ADD;
        end else if (op32 == SW_CODE) begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALUOP_ADD;
            uses_rt        = 1'b1;
        end else if (op32 == BR_CODE) begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALUOP_SUB;
            uses_rt     = 1'b1;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID/EX control register with load-use stall FSM, taken-branch squash
// and saturating stall/flush performance counters.
module pipe_ctrl_unit
    import pipe_pkg::*;
#(
    parameter int unsigned OPCODE_W   = pipe_pkg::OPCODE_W,
    parameter int unsigned REG_W      = pipe_pkg::REG_W,
    parameter int unsigned LAST_RTYPE = pipe_pkg::LAST_RTYPE,
    parameter int unsigned LAST_ITYPE = pipe_pkg::LAST_ITYPE,
    parameter int unsigned OP_LW      = pipe_pkg::OP_LW,
    parameter int unsigned OP_SW      = pipe_pkg::OP_SW,
    parameter int unsigned OP_BR      = pipe_pkg::OP_BR,
    parameter int unsigned LU_BUBBLES = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                br_taken,
    output logic                ex_valid,
    output logic                ex_reg_dst,
    output logic                ex_branch,
    output logic                ex_mem_read,
    output logic                ex_mem_to_reg,
    output logic                ex_mem_write,
    output logic                ex_alu_src,
    output logic                ex_reg_write,
    output logic [1:0]          ex_alu_op,
    output logic [REG_W-1:0]    ex_rt,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                ifid_flush,
    output logic                exmem_flush,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    ctrl_t      id_ctrl;
    ctrl_t      ex_ctrl;
    logic       id_illegal;
    logic       id_uses_rt;
    logic       hz;
    logic       stalling;
    state_t     state;
    logic [2:0] bub_left;

    ctrl_decode #(
        .OP_W    (OPCODE_W),
        .R_LAST  (LAST_RTYPE),
        .I_LAST  (LAST_ITYPE),
        .LW_CODE (OP_LW),
        .SW_CODE (OP_SW),
        .BR_CODE (OP_BR)
    ) u_decode (
        .opcode  (id_opcode),
        .ctrl    (id_ctrl),
        .illegal (id_illegal),
        .uses_rt (id_uses_rt)
    );

    assign hz = ex_valid & ex_ctrl.mem_read & (ex_rt != '0) & id_valid &
                ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    assign stalling = (state == ST_STALL) | hz;

    // A taken branch overrides any stall: the front end must refetch now.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (br_taken) begin
            ifid_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (stalling) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            bub_left   <= '0;
            ex_ctrl    <= CTRL_NOP;
            ex_valid   <= 1'b0;
            ex_rt      <= '0;
            illegal_op <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else if (br_taken) begin
            state      <= ST_RUN;
            bub_left   <= '0;
            ex_ctrl    <= CTRL_NOP;
            ex_valid   <= 1'b0;
            ex_rt      <= '0;
            illegal_op <= 1'b0;
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end else if (stalling) begin
            ex_ctrl    <= CTRL_NOP;
            ex_valid   <= 1'b0;
            ex_rt      <= '0;
            illegal_op <= 1'b0;
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (state == ST_STALL) begin
                if (bub_left == 3'd1) state <= ST_RUN;
                bub_left <= bub_left - 3'd1;
            end else if (LU_BUBBLES > 1) begin
                state    <= ST_STALL;
                bub_left <= 3'(LU_BUBBLES - 1);
            end
        end else if (id_valid && !id_illegal) begin
            ex_ctrl    <= id_ctrl;
            ex_valid   <= 1'b1;
            ex_rt      <= id_rt;
            illegal_op <= 1'b0;
        end else begin
            // Undefined opcodes still occupy the slot so the fault is visible.
            ex_ctrl    <= CTRL_NOP;
            ex_valid   <= id_valid;
            ex_rt      <= '0;
            illegal_op <= id_valid;
        end
    end

    assign ex_reg_dst    = ex_ctrl.reg_dst;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_alu_op     = ex_ctrl.alu_op;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: two instances (1 bubble / wide counters,
// 3 bubbles / 2-bit counters) checked against an instruction-level model.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [5:0] id_opcode = '0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       br_taken = 1'b0;

    logic        ex_valid_a, ex_reg_dst_a, ex_branch_a, ex_mem_read_a, ex_mem_to_reg_a;
    logic        ex_mem_write_a, ex_alu_src_a, ex_reg_write_a, illegal_op_a;
    logic        pc_write_a, ifid_write_a, ifid_flush_a, exmem_flush_a;
    logic [1:0]  ex_alu_op_a;
    logic [4:0]  ex_rt_a;
    logic [15:0] stall_cnt_a, flush_cnt_a;

    logic        ex_valid_b, ex_reg_dst_b, ex_branch_b, ex_mem_read_b, ex_mem_to_reg_b;
    logic        ex_mem_write_b, ex_alu_src_b, ex_reg_write_b, illegal_op_b;
    logic        pc_write_b, ifid_write_b, ifid_flush_b, exmem_flush_b;
    logic [1:0]  ex_alu_op_b;
    logic [4:0]  ex_rt_b;
    logic [1:0]  stall_cnt_b, flush_cnt_b;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.LU_BUBBLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .br_taken(br_taken),
        .ex_valid(ex_valid_a), .ex_reg_dst(ex_reg_dst_a), .ex_branch(ex_branch_a),
        .ex_mem_read(ex_mem_read_a), .ex_mem_to_reg(ex_mem_to_reg_a),
        .ex_mem_write(ex_mem_write_a), .ex_alu_src(ex_alu_src_a),
        .ex_reg_write(ex_reg_write_a), .ex_alu_op(ex_alu_op_a), .ex_rt(ex_rt_a),
        .pc_write(pc_write_a), .ifid_write(ifid_write_a), .ifid_flush(ifid_flush_a),
        .exmem_flush(exmem_flush_a), .illegal_op(illegal_op_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    pipe_ctrl_unit #(.LU_BUBBLES(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .br_taken(br_taken),
        .ex_valid(ex_valid_b), .ex_reg_dst(ex_reg_dst_b), .ex_branch(ex_branch_b),
        .ex_mem_read(ex_mem_read_b), .ex_mem_to_reg(ex_mem_to_reg_b),
        .ex_mem_write(ex_mem_write_b), .ex_alu_src(ex_alu_src_b),
        .ex_reg_write(ex_reg_write_b), .ex_alu_op(ex_alu_op_b), .ex_rt(ex_rt_b),
        .pc_write(pc_write_b), .ifid_write(ifid_write_b), .ifid_flush(ifid_flush_b),
        .exmem_flush(exmem_flush_b), .illegal_op(illegal_op_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    typedef struct packed {
        logic [3:0]  comb;
        logic        valid;
        logic [8:0]  ctrl;
        logic [4:0]  rt;
        logic        ill;
        logic [15:0] sc;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        logic chkComb;
        obs_t e0;
        obs_t e1;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;

    // Instruction-level model state for both instances
    int mExValid[2], mExOp[2], mExRt[2], mLeft[2], mStall[2], mFlush[2];
    int lu[2]   = '{1, 3};
    int cmax[2] = '{65535, 3};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int opClass(input int op);
        if (op <= 4) return 0;
        if (op <= 9) return 1;
        if (op == 10) return 2;
        if (op == 11) return 3;
        if (op == 12) return 4;
        return 5;
    endfunction

    // {RegDst,Branch,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,ALUOp}
    function automatic logic [8:0] ctrlOf(input int op);
        case (opClass(op))
            0:       return 9'b1_0_0_0_0_0_1_10;
            1:       return 9'b0_0_0_0_0_1_1_10;
            2:       return 9'b0_0_1_1_0_1_1_00;
            3:       return 9'b0_0_0_0_1_1_0_00;
            4:       return 9'b0_1_0_0_0_0_0_01;
            default: return 9'b0;
        endcase
    endfunction

    function automatic obs_t modelRegs(input int k, input logic [3:0] comb);
        obs_t o;
        logic legal;
        legal   = (opClass(mExOp[k]) != 5);
        o.comb  = comb;
        o.valid = (mExValid[k] != 0);
        o.ctrl  = o.valid ? ctrlOf(mExOp[k]) : 9'b0;
        o.rt    = (o.valid && legal) ? 5'(mExRt[k]) : 5'd0;
        o.ill   = o.valid && !legal;
        o.sc    = 16'(mStall[k]);
        o.fc    = 16'(mFlush[k]);
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input int op,
                                 input int rs, input int rt, input logic br);
        exp_t e;
        obs_t o[2];
        @(negedge clk);
        rst = r; id_valid = v; id_opcode = 6'(op); id_rs = 5'(rs); id_rt = 5'(rt); br_taken = br;
        for (int k = 0; k < 2; k++) begin
            bit usesRt, hz, stall;
            logic [3:0] comb;
            usesRt = (opClass(op) == 0) || (op == 11) || (op == 12);
            hz = (mExValid[k] != 0) && (mExOp[k] == 10) && (mExRt[k] != 0) && v &&
                 ((mExRt[k] == rs) || (usesRt && mExRt[k] == rt));
            stall = (mLeft[k] > 0) || hz;
            comb = br ? 4'b1111 : (stall ? 4'b0000 : 4'b1100);
            if (r) begin
                mExValid[k] = 0; mExOp[k] = 0; mExRt[k] = 0;
                mLeft[k] = 0; mStall[k] = 0; mFlush[k] = 0;
            end else if (br) begin
                mExValid[k] = 0; mLeft[k] = 0;
                if (mFlush[k] < cmax[k]) mFlush[k]++;
            end else if (stall) begin
                mExValid[k] = 0;
                if (mStall[k] < cmax[k]) mStall[k]++;
                mLeft[k] = (mLeft[k] > 0) ? mLeft[k] - 1 : lu[k] - 1;
            end else begin
                mExValid[k] = v; mExOp[k] = op; mExRt[k] = rt;
            end
            o[k] = modelRegs(k, comb);
        end
        e.chkComb = !r;
        e.e0 = o[0];
        e.e1 = o[1];
        q.push_back(e);
    endtask

    // Monitor: combinational outputs just before the edge, registers just after
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (q.size() > 0) begin
                e = q[0];
                if (e.chkComb) begin
                    checkOutput("comb_a", 32'({pc_write_a, ifid_write_a, ifid_flush_a, exmem_flush_a}), 32'(e.e0.comb));
                    checkOutput("comb_b", 32'({pc_write_b, ifid_write_b, ifid_flush_b, exmem_flush_b}), 32'(e.e1.comb));
                end
                @(posedge clk);
                #1;
                checkOutput("ex_valid_a", 32'(ex_valid_a), 32'(e.e0.valid));
                checkOutput("ex_ctrl_a", 32'({ex_reg_dst_a, ex_branch_a, ex_mem_read_a, ex_mem_to_reg_a,
                            ex_mem_write_a, ex_alu_src_a, ex_reg_write_a, ex_alu_op_a}), 32'(e.e0.ctrl));
                checkOutput("ex_rt_a", 32'(ex_rt_a), 32'(e.e0.rt));
                checkOutput("illegal_a", 32'(illegal_op_a), 32'(e.e0.ill));
                checkOutput("stall_cnt_a", 32'(stall_cnt_a), 32'(e.e0.sc));
                checkOutput("flush_cnt_a", 32'(flush_cnt_a), 32'(e.e0.fc));
                checkOutput("ex_valid_b", 32'(ex_valid_b), 32'(e.e1.valid));
                checkOutput("ex_ctrl_b", 32'({ex_reg_dst_b, ex_branch_b, ex_mem_read_b, ex_mem_to_reg_b,
                            ex_mem_write_b, ex_alu_src_b, ex_reg_write_b, ex_alu_op_b}), 32'(e.e1.ctrl));
                checkOutput("ex_rt_b", 32'(ex_rt_b), 32'(e.e1.rt));
                checkOutput("illegal_b", 32'(illegal_op_b), 32'(e.e1.ill));
                checkOutput("stall_cnt_b", 32'(stall_cnt_b), 32'(e.e1.sc));
                checkOutput("flush_cnt_b", 32'(flush_cnt_b), 32'(e.e1.fc));
                void'(q.pop_front());
            end
        end
    end

    typedef struct { logic r; logic v; int op; int rs; int rt; logic br; } stim_t;

    stim_t dir[] = '{
        '{1, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0},
        '{0, 1, 3, 1, 2, 0},                                          // R-type decode
        '{0, 1, 10, 0, 5, 0}, '{0, 1, 2, 5, 6, 0}, '{0, 1, 2, 5, 6, 0},
        '{0, 1, 2, 5, 6, 0}, '{0, 1, 2, 5, 6, 0},                     // load-use on rs
        '{0, 1, 10, 0, 0, 0}, '{0, 1, 0, 0, 0, 0},                    // $0 never stalls
        '{0, 1, 10, 1, 7, 0}, '{0, 1, 6, 2, 7, 0}, '{0, 1, 6, 2, 7, 0},  // I-type ignores rt
        '{0, 1, 10, 0, 3, 0}, '{0, 1, 1, 3, 1, 0}, '{0, 1, 1, 3, 1, 1},
        '{0, 1, 1, 3, 1, 0},                                          // branch aborts stall
        '{0, 1, 40, 0, 9, 0}, '{0, 0, 0, 0, 0, 0},                    // illegal, then idle
        '{0, 1, 10, 0, 4, 0}, '{0, 1, 0, 4, 0, 0}, '{1, 1, 0, 4, 0, 0},
        '{0, 1, 0, 4, 0, 0}, '{0, 1, 0, 4, 0, 0}                      // reset mid-stall
    };

    initial begin
        for (int k = 0; k < 2; k++) begin
            mExValid[k] = 0; mExOp[k] = 0; mExRt[k] = 0;
            mLeft[k] = 0; mStall[k] = 0; mFlush[k] = 0;
        end
        foreach (dir[i])
            applyStimulus(dir[i].r, dir[i].v, dir[i].op, dir[i].rs, dir[i].rt, dir[i].br);
        for (int i = 0; i < 800; i++) begin
            int op;
            op = ($urandom_range(0, 19) < 16) ? int'($urandom_range(0, 12)) : int'($urandom_range(13, 63));
            applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 7) != 0, op,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          $urandom_range(0, 15) == 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #2;
        checkOutput("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
